// File: rtl/top_core_spi.sv
// top_core_spi: SPI-slave controlled GPIO register bank.
// An external SPI master (mode 0, MSB first) sends frames of CMD[7:0], ADDR[31:0]
// and DATA[31:0]. CMD 8'h02 writes a register and CMD 8'h03 reads one. GPIO_OUT
// drives gpio_o. spi_sclk, spi_cs and spi_sdi0 are oversampled in clk_i.
// Optional feature macro: SPI_READ_EN. It builds the read path: the CMD 8'h03
// decode, the register read mux and the spi_sdo0 shifter. Without it, spi_sdo0
// is constant 0.
// Ports:
//   clk_i, rst_i        system clock; asynchronous active-high reset
//   fetch_enable_i      reported in STATUS[0]
//   en_ifetch_i         reported in STATUS[1]
//   spi_sclk/cs/sdi0..3 SPI slave inputs (sdi1..3 unused)
//   spi_sdo0..3         serial read data on sdo0; sdo1..3 tied 0
//   spi_mode            constant 2'b00 (single-bit link)
//   gpio_o              GPIO_OUT register value
//   o_dbg_state         frame FSM state: 0 IDLE, 1 CMD, 2 ADDR, 3 WDATA, 4 RDATA, 5 DONE
// Handshake: the link has no valid/ready. A bit is valid at each synchronized
// sclk rising edge while cs is low. A frame is accepted only when all 72 bits
// arrive before cs rises.
module top_core_spi #(
    parameter logic [31:0] GPIO_BASE = 32'h3001_0000,
    parameter logic [31:0] ID_VALUE  = 32'h5350_4731
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_enable_i,
    input  logic        en_ifetch_i,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_sdi0,
    input  logic        spi_sdi1,
    input  logic        spi_sdi2,
    input  logic        spi_sdi3,
    output logic        spi_sdo0,
    output logic        spi_sdo1,
    output logic        spi_sdo2,
    output logic        spi_sdo3,
    output logic [1:0]  spi_mode,
    output logic [31:0] gpio_o,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    logic [2:0]  r_sclk_s;   // [1:0] synchronizer, [2] previous value for edge detect
    logic [1:0]  r_cs_s;
    logic [1:0]  r_sdi_s;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_shift;
    logic [7:0]  r_cmd;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_wr_pend;
    logic [31:0] r_gpio;

    logic        w_rise;
    logic        w_fall;
    logic        w_cs_n;
    logic        w_sdi;
    logic [31:0] w_shift_in;

    assign w_rise     = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_fall     = ~r_sclk_s[1] & r_sclk_s[2];
    assign w_cs_n     = r_cs_s[1];
    assign w_sdi      = r_sdi_s[1];
    assign w_shift_in = {r_shift[30:0], w_sdi};

    assign spi_sdo1    = 1'b0;
    assign spi_sdo2    = 1'b0;
    assign spi_sdo3    = 1'b0;
    assign spi_mode    = 2'b00;
    assign gpio_o      = r_gpio;
    assign o_dbg_state = r_state;

`ifdef SPI_READ_EN
    logic [31:0] r_rd;
    logic        r_sdo;
    logic [31:0] w_rd_val;

    assign spi_sdo0 = r_sdo;

    // Read mux, evaluated on the completed address so it can be latched at
    // the last ADDR bit.
    always_comb begin
        w_rd_val = 32'h0;
        if (w_shift_in[31:8] == GPIO_BASE[31:8]) begin
            case (w_shift_in[7:0])
                8'h00:   w_rd_val = ID_VALUE;
                8'h04:   w_rd_val = {30'b0, en_ifetch_i, fetch_enable_i};
                8'h14:   w_rd_val = r_gpio;
                8'h1C:   w_rd_val = 32'h0;
                8'h20:   w_rd_val = 32'h0;
                default: w_rd_val = 32'hDEAD_BEEF;
            endcase
        end
    end
`else
    assign spi_sdo0 = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_sclk_s  <= 3'b000;
            r_cs_s    <= 2'b11;
            r_sdi_s   <= 2'b00;
            r_bit_cnt <= 5'd0;
            r_shift   <= 32'h0;
            r_cmd     <= 8'h0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wr_pend <= 1'b0;
            r_gpio    <= 32'h0;
`ifdef SPI_READ_EN
            r_rd      <= 32'h0;
            r_sdo     <= 1'b0;
`endif
        end else begin
            r_sclk_s  <= {r_sclk_s[1:0], spi_sclk};
            r_cs_s    <= {r_cs_s[0], spi_cs};
            r_sdi_s   <= {r_sdi_s[0], spi_sdi0};
            r_wr_pend <= 1'b0;

            // The commit runs one cycle after the 72nd rising edge. The frame
            // is already complete at that point, so a later cs rise cannot cancel it.
            if (r_wr_pend) begin
                if (r_addr == GPIO_BASE + 32'h14)
                    r_gpio <= r_wdata;
                else if (r_addr == GPIO_BASE + 32'h1C)
                    r_gpio <= r_gpio | r_wdata;
                else if (r_addr == GPIO_BASE + 32'h20)
                    r_gpio <= r_gpio & ~r_wdata;
            end

            if (w_cs_n) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 5'd0;
`ifdef SPI_READ_EN
                r_sdo     <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_CMD;
                        r_bit_cnt <= 5'd0;
                    end
                    S_CMD: if (w_rise) begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            r_cmd     <= w_shift_in[7:0];
                            r_bit_cnt <= 5'd0;
                            r_state   <= S_ADDR;
                        end
                    end
                    S_ADDR: if (w_rise) begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd31) begin
                            r_addr    <= w_shift_in;
                            r_bit_cnt <= 5'd0;
                            if (r_cmd == 8'h02)
                                r_state <= S_WDATA;
`ifdef SPI_READ_EN
                            else if (r_cmd == 8'h03) begin
                                r_state <= S_RDATA;
                                r_rd    <= w_rd_val;
                            end
`endif
                            else
                                r_state <= S_DONE;
                        end
                    end
                    S_WDATA: if (w_rise) begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd31) begin
                            r_wdata   <= w_shift_in;
                            r_wr_pend <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                    S_RDATA: begin
`ifdef SPI_READ_EN
                        // Each falling edge presents the next bit, starting with bit 31.
                        if (w_fall) begin
                            r_sdo <= r_rd[31];
                            r_rd  <= {r_rd[30:0], 1'b0};
                        end
`endif
                        if (w_rise) begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd31)
                                r_state <= S_DONE;
                        end
                    end
                    default: r_state <= S_DONE;  // DONE holds until cs rises
                endcase
            end
        end
    end

endmodule

// File: tb/tb_top_core_spi.sv
module tb_top_core_spi;

  localparam logic [31:0] BASE = 32'h3001_0000;
  localparam logic [31:0] ID   = 32'h5350_4731;
`ifdef SPI_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        fetch_en, en_ifetch;
  logic        sclk, cs, sdi0, sdi1, sdi2, sdi3;
  logic        sdo0, sdo1, sdo2, sdo3;
  logic [1:0]  mode;
  logic [31:0] gpio;
  logic [2:0]  dbg_state;

  top_core_spi dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_enable_i(fetch_en), .en_ifetch_i(en_ifetch),
    .spi_sclk(sclk), .spi_cs(cs),
    .spi_sdi0(sdi0), .spi_sdi1(sdi1), .spi_sdi2(sdi2), .spi_sdi3(sdi3),
    .spi_sdo0(sdo0), .spi_sdo1(sdo1), .spi_sdo2(sdo2), .spi_sdo3(sdo3),
    .spi_mode(mode), .gpio_o(gpio), .o_dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_gpio = 32'h0;

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic fe, input logic en);
    if (a[31:8] != BASE[31:8]) return 32'h0;
    case (a - BASE)
      32'h00: return ID;
      32'h04: return {30'b0, en, fe};
      32'h14: return m_gpio;
      32'h1C, 32'h20: return 32'h0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (a == BASE + 32'h14) m_gpio = d;
    else if (a == BASE + 32'h1C) m_gpio = m_gpio | d;
    else if (a == BASE + 32'h20) m_gpio = m_gpio & ~d;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];     // expected gpio_o after each frame
  logic [31:0] exp_rd_q[$];  // expected word shifted out on sdo0
  logic [31:0] rd_obs;
  logic        chk_stb = 1'b0;
  int          frame_no = 0;

  always @(negedge clk) begin
    if (chk_stb) begin
      if (exp_q.size() == 0 || exp_rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty frame=%0d", frame_no);
      end else begin
        check($sformatf("gpio_frame%0d", frame_no), gpio, exp_q.pop_front());
        check($sformatf("sdo_frame%0d", frame_no), rd_obs, exp_rd_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // nbits < 72 aborts by raising cs early; rst_at >= 0 asserts reset mid-frame.
  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input int nbits, input int rst_at);
    logic [71:0] fbits;
    logic [31:0] exp_rd;
    bit          full;
    bit          reset_hit;
    fbits     = {cmd, addr, data};
    full      = (nbits == 72) && (rst_at < 0);
    reset_hit = 1'b0;
    exp_rd    = (READ_EN && full && cmd == 8'h03) ? model_read(addr, fetch_en, en_ifetch) : 32'h0;
    rd_obs    = 32'h0;
    frame_no++;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sdi0 = fbits[71-i];
      repeat (4) @(negedge clk);
      if (i >= 40) rd_obs = {rd_obs[30:0], sdo0};  // master samples just before the rise
      sclk = 1'b1;
      if (i == rst_at) begin
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_async_gpio", gpio, 32'h0);
        check("rst_async_state", {29'b0, dbg_state}, 32'h0);
        m_gpio = 32'h0;
        reset_hit = 1'b1;
        sclk = 1'b0;
        break;
      end
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs = 1'b1;
    if (reset_hit) begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
    end
    repeat (4) @(negedge clk);
    if (full && cmd == 8'h02) model_write(addr, data);
    exp_q.push_back(m_gpio);
    exp_rd_q.push_back(exp_rd);
    @(posedge clk);
    chk_stb = 1'b1;
    @(posedge clk);
    chk_stb = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] offs[9] = '{32'h00, 32'h04, 32'h14, 32'h1C, 32'h20, 32'h08, 32'h10, 32'h15, 32'hFC};

  initial begin
    fetch_en = 1'b0; en_ifetch = 1'b0;
    sclk = 1'b0; cs = 1'b1; sdi0 = 1'b0; sdi1 = 1'b0; sdi2 = 1'b0; sdi3 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_gpio", gpio, 32'h0);
    check("reset_sdo0", {31'b0, sdo0}, 32'h0);
    check("reset_state", {29'b0, dbg_state}, 32'h0);
    check("spi_mode", {30'b0, mode}, 32'h0);
    check("sdo123", {29'b0, sdo1, sdo2, sdo3}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed frames
    spi_frame(8'h02, BASE + 32'h14, 32'h0000_00FF, 72, -1);
    spi_frame(8'h02, BASE + 32'h14, 32'h0F0F_0000, 72, -1);
    spi_frame(8'h02, BASE + 32'h1C, 32'h0000_00F0, 72, -1);
    spi_frame(8'h02, BASE + 32'h20, 32'h0F00_0000, 72, -1);
    spi_frame(8'h02, BASE + 32'h14, 32'h1234_5678, 50, -1);   // aborted
    spi_frame(8'hAA, BASE + 32'h14, 32'h1234_5678, 72, -1);   // unknown command
    spi_frame(8'h03, BASE + 32'h00, 32'h0, 72, -1);
    fetch_en = 1'b1; en_ifetch = 1'b0;
    spi_frame(8'h03, BASE + 32'h04, 32'h0, 72, -1);
    spi_frame(8'h03, BASE + 32'h14, 32'h0, 72, -1);
    spi_frame(8'h03, BASE + 32'h08, 32'h0, 72, -1);
    spi_frame(8'h03, 32'h3002_0014, 32'h0, 72, -1);
    spi_frame(8'h02, 32'h3002_0014, 32'hFFFF_0000, 72, -1);  // outside block: ignored
    spi_frame(8'h02, BASE + 32'h14, 32'hFFFF_FFFF, 72, -1);
    spi_frame(8'h02, BASE + 32'h14, 32'hA5A5_A5A5, 72, 45);  // reset mid-frame
    spi_frame(8'h02, BASE + 32'h14, 32'h0000_C3C3, 72, -1);

    // Randomized frames
    for (int n = 0; n < 24; n++) begin
      logic [7:0]  c;
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 3);
      c = (r < 2) ? 8'h02 : (r == 2) ? 8'h03 : 8'($urandom_range(0, 255));
      a = ($urandom_range(0, 7) == 0) ? $urandom() : BASE + offs[$urandom_range(0, 8)];
      fetch_en  = 1'($urandom_range(0, 1));
      en_ifetch = 1'($urandom_range(0, 1));
      spi_frame(c, a, $urandom(), 72, -1);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
